// File: rtl/ysyx_23060286_ifu.sv
// ysyx_23060286_ifu: instruction fetch unit, REQ/WAIT/HOLD FSM with redirect and stale-response flush.
// Optional misaligned-pc fault generation under YSYX_23060286_IFU_ALIGN_CHK_EN.
module ysyx_23060286_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_fault
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;
  state_t state, state_n;
  logic [31:0] pc, pc_n, out_inst_n, out_pc_n;
  logic flush, flush_n, out_fault_n, misal, drop;
`ifdef YSYX_23060286_IFU_ALIGN_CHK_EN
  assign misal = |pc[1:0];
`else
  assign misal = 1'b0;
`endif
  assign imem_req_valid = rst_n && state == REQ && !misal;
  assign imem_req_addr  = pc;
  assign out_valid      = rst_n && state == HOLD;
  assign drop           = flush || redirect_valid;
  // A redirect in REQ that coincides with an accepted request still leaves that
  // request outstanding, so its response is waited for in WAIT and discarded.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    flush_n     = flush;
    out_inst_n  = out_inst;
    out_pc_n    = out_pc;
    out_fault_n = out_fault;
    case (state)
      REQ:
        if (redirect_valid) begin
          pc_n = redirect_pc;
          if (imem_req_valid && imem_req_ready) begin
            state_n = WAIT;
            flush_n = 1'b1;
          end
        end else if (misal) begin
          state_n     = HOLD;
          out_inst_n  = NOP;
          out_pc_n    = pc;
          out_fault_n = 1'b1;
        end else if (imem_req_ready) state_n = WAIT;
      WAIT: begin
        pc_n = redirect_valid ? redirect_pc : pc;
        if (imem_rsp_valid) begin
          flush_n = 1'b0;
          state_n = drop ? REQ : HOLD;
          if (!drop) begin
            out_inst_n  = imem_rsp_err ? NOP : imem_rsp_data;
            out_pc_n    = pc;
            out_fault_n = imem_rsp_err;
          end
        end else if (redirect_valid) flush_n = 1'b1;
      end
      HOLD:
        if (redirect_valid) begin
          pc_n    = redirect_pc;
          state_n = REQ;
        end else if (out_ready) begin
          pc_n    = out_pc + 32'd4;
          state_n = REQ;
        end
      default: state_n = REQ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= REQ;
      pc        <= RESET_PC;
      flush     <= 1'b0;
      out_inst  <= '0;
      out_pc    <= '0;
      out_fault <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      flush     <= flush_n;
      out_inst  <= out_inst_n;
      out_pc    <= out_pc_n;
      out_fault <= out_fault_n;
    end
endmodule

// File: tb/tb_ysyx_23060286_ifu.sv
// tb_ysyx_23060286_ifu: table-driven fetches plus redirect/reset corner sequences, scoreboard-checked.
module tb_ysyx_23060286_ifu;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 0, rst_n = 0, redirect_valid = 0, imem_req_ready = 0, imem_rsp_valid = 0;
  logic imem_rsp_err = 0, out_ready = 0, imem_req_valid, out_valid, out_fault;
  logic [31:0] redirect_pc = 0, imem_rsp_data = 0, imem_req_addr, out_inst, out_pc;
  int checks = 0, errors = 0;
  typedef struct {logic [31:0] pc; logic [31:0] inst; logic fault;} exp_t;
  typedef struct {logic [31:0] addr; logic [31:0] data; logic err; int req_lat; int rsp_lat; int hold;} rec_t;
  exp_t sb[$];
  rec_t tbl[4];
  ysyx_23060286_ifu dut (
    .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_fault(out_fault)
  );
  always #5 clk = ~clk;
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic wait_req;
    for (int i = 0; i < 20 && !imem_req_valid; i++) cyc;
    chk("req_valid", {31'd0, imem_req_valid}, 32'd1);
  endtask
  task automatic issue(input rec_t r);
    wait_req;
    chk("req_addr", imem_req_addr, r.addr);
    for (int i = 0; i < r.req_lat; i++) begin
      cyc;
      chk("addr_stable", imem_req_addr, r.addr);
    end
    imem_req_ready = 1;
    sb.push_back('{r.addr, r.err ? NOP : r.data, r.err});
    cyc;
    imem_req_ready = 0;
    for (int i = 0; i < r.rsp_lat; i++) begin
      cyc;
      chk("no_early_offer", {31'd0, out_valid}, 32'd0);
    end
    imem_rsp_valid = 1;
    imem_rsp_data  = r.data;
    imem_rsp_err   = r.err;
    cyc;
    imem_rsp_valid = 0;
    imem_rsp_err   = 0;
    chk("out_valid", {31'd0, out_valid}, 32'd1);
  endtask
  task automatic offer(input int hold);
    exp_t e;
    logic [31:0] sp = out_pc, si = out_inst;
    for (int i = 0; i < hold; i++) begin
      cyc;
      chk("hold_pc", out_pc, sp);
      chk("hold_inst", out_inst, si);
      chk("hold_noreq", {31'd0, imem_req_valid}, 32'd0);
    end
    chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("out_pc", out_pc, e.pc);
      chk("out_inst", out_inst, e.inst);
      chk("out_fault", {31'd0, out_fault}, {31'd0, e.fault});
    end
    chk("offer_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1;
    cyc;
    out_ready = 0;
  endtask
  initial begin
    tbl[0] = '{32'h8000_0000, 32'h0010_0073, 1'b0, 0, 0, 5};
    tbl[1] = '{32'h8000_0004, 32'h0000_0293, 1'b0, 2, 1, 0};
    tbl[2] = '{32'h8000_0008, 32'hdead_beef, 1'b1, 0, 0, 1};
    tbl[3] = '{32'h8000_000c, 32'h00a0_0513, 1'b0, 1, 3, 2};
    repeat (3) cyc;
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    rst_n = 1;
    cyc;
    chk("first_req", {31'd0, imem_req_valid}, 32'd1);
    chk("first_addr", imem_req_addr, 32'h8000_0000);
    for (int i = 0; i < 4; i++) begin
      issue(tbl[i]);
      offer(tbl[i].hold);
    end
    // redirect while waiting; the late response must be dropped
    wait_req;
    chk("a_addr", imem_req_addr, 32'h8000_0010);
    imem_req_ready = 1;
    cyc;
    imem_req_ready = 0;
    redirect_valid = 1;
    redirect_pc = 32'h8000_0100;
    cyc;
    redirect_valid = 0;
    chk("a_wait_noreq", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1;
    imem_rsp_data = 32'h1111_1111;
    cyc;
    imem_rsp_valid = 0;
    chk("a_stale_drop", {31'd0, out_valid}, 32'd0);
    chk("a_redir_addr", imem_req_addr, 32'h8000_0100);
    issue('{32'h8000_0100, 32'h0000_0033, 1'b0, 0, 0, 0});
    offer(0);
    // redirect in HOLD with simultaneous out_ready: the offered word is discarded
    issue('{32'h8000_0104, 32'h0000_0433, 1'b0, 0, 0, 0});
    redirect_valid = 1;
    redirect_pc = 32'h8000_0102;
    out_ready = 1;
    cyc;
    redirect_valid = 0;
    out_ready = 0;
    chk("b_drop_valid", {31'd0, out_valid}, 32'd0);
    if (sb.size() != 0) void'(sb.pop_front());
`ifdef YSYX_23060286_IFU_ALIGN_CHK_EN
    chk("b_misal_noreq", {31'd0, imem_req_valid}, 32'd0);
    cyc;
    sb.push_back('{32'h8000_0102, NOP, 1'b1});
    offer(0);
`else
    issue('{32'h8000_0102, 32'h0000_0513, 1'b0, 0, 0, 0});
    offer(0);
    chk("b_unaligned_next", imem_req_addr, 32'h8000_0106);
`endif
    redirect_valid = 1;
    redirect_pc = 32'h8000_0200;
    cyc;
    redirect_valid = 0;
    issue('{32'h8000_0200, 32'h0000_0593, 1'b0, 0, 0, 0});
    offer(0);
    // redirect coinciding with the response
    wait_req;
    chk("c_addr", imem_req_addr, 32'h8000_0204);
    imem_req_ready = 1;
    cyc;
    imem_req_ready = 0;
    redirect_valid = 1;
    redirect_pc = 32'h8000_0300;
    imem_rsp_valid = 1;
    cyc;
    redirect_valid = 0;
    imem_rsp_valid = 0;
    chk("c_no_offer", {31'd0, out_valid}, 32'd0);
    chk("c_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("c_addr2", imem_req_addr, 32'h8000_0300);
    // reset during WAIT
    imem_req_ready = 1;
    cyc;
    imem_req_ready = 0;
    #2 rst_n = 0;
    #1;
    chk("d_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("d_out_valid", {31'd0, out_valid}, 32'd0);
    chk("d_out_pc", out_pc, 32'd0);
    chk("d_out_inst", out_inst, 32'd0);
    cyc;
    rst_n = 1;
    chk("d_addr", imem_req_addr, 32'h8000_0000);
    imem_rsp_valid = 1;
    cyc;
    imem_rsp_valid = 0;
    chk("d_ignore_rsp", {31'd0, out_valid}, 32'd0);
    chk("d_still_req", {31'd0, imem_req_valid}, 32'd1);
    issue(tbl[0]);
    offer(0);
    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
